// File: rtl/fifo_pkg.sv
// Shared types and defaults for the sync_fifo read-side streamer.
// Holds the read FSM encoding and width defaults.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer between FIFO read data and the stream.
// Head is always entry 0; push and pop may coincide at any occupancy.
module fifo_rd_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    occ
);

  logic [DW-1:0] e0_q, e0_d;
  logic [DW-1:0] e1_q, e1_d;
  logic [1:0]    occ_q, occ_d;

  // Next-entry and occupancy update for push/pop combinations.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = din;
        else               e1_d = din;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = din;
        end else begin
          e0_d = din;
        end
      end
      default: ;
    endcase
  end

  // Entry and occupancy registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign dout = e0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for sync_fifo: issues pops, absorbs the 1-cycle
// read latency through a 2-entry skid and presents a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  idle
);

  rd_state_e            state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           occ;
  logic                 pop;
  logic                 rd;
  logic [2:0]           load;

  assign pop = m_valid && m_ready;

  // A word leaving this cycle frees its slot for a read issued now,
  // which is what sustains one word per cycle under m_ready=1.
  assign load = {1'b0, occ} + {2'b00, inflight_q};

  // Read strobe and next-state decode.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    if (state_q == RUN && enable && !fifo_empty)
      rd = (load - {2'b00, pop}) < 3'd2;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable) state_d = STOP;
      STOP: begin
        if (enable)           state_d = RUN;
        else if (!inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bookkeeping: in-flight flag tracks last strobe, counter wraps.
  always_comb begin
    inflight_d = rd;
    cnt_d      = cnt_q;
    if (pop) cnt_d = cnt_q + 1'b1;
  end

  // State, in-flight and delivered-count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  fifo_rd_skid #(
    .DW(DATA_WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  (fifo_data_out),
    .pop  (pop),
    .dout (m_data),
    .occ  (occ)
  );

  assign fifo_rd_cs = rd;
  assign fifo_rd_en = rd;
  assign m_valid    = (occ != 2'd0);
  assign pop_count  = cnt_q;
  assign idle       = (state_q == IDLE) && (occ == 2'd0)
                      && !inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: emulates the sync_fifo, drains it through
// the DUT and scores every cycle against a queue-based model.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_cs;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] pop_count;
  logic          idle;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_cs   (fifo_rd_cs),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .pop_count    (pop_count),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] skid_m[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] wr_log[$];
  bit            inf_m;
  logic [DW-1:0] inf_w;
  int            st_m;
  int            cnt_m;
  bit            model_ok = 0;

  int cyc = 0;
  int rd_n, first_rd, last_rd;
  int v_n, first_v, last_v;

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    total++;
    if (a !== e)
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, a, e, $time);
    else
      passed++;
  endtask

  task automatic clr_stats();
    rd_n = 0; first_rd = -1; last_rd = -1;
    v_n  = 0; first_v  = -1; last_v  = -1;
    got.delete();
  endtask

  task automatic put(logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: compare at negedge, then advance FIFO and model.
  task automatic step();
    bit            e_valid, e_pop, e_rd, e_idle, d_rd;
    logic [DW-1:0] hd;
    @(negedge clk);
    e_valid = skid_m.size() != 0;
    e_pop   = e_valid && m_ready;
    e_rd    = st_m == 1 && enable && fifo_q.size() != 0
              && (skid_m.size() + int'(inf_m)
                  - int'(e_pop)) < 2;
    e_idle  = st_m == 0 && !e_valid && !inf_m;
    hd      = fifo_q.size() != 0 ? fifo_q[0] : '0;
    if (model_ok) begin
      chk("rd_cs", fifo_rd_cs, e_rd);
      chk("rd_en", fifo_rd_en, e_rd);
      chk("m_valid", m_valid, e_valid);
      chk("idle", idle, e_idle);
      chk("pop_count", pop_count, cnt_m % 16);
      if (e_valid) chk("m_data", m_data, skid_m[0]);
      if (fifo_empty) chk("rd_on_empty", fifo_rd_cs, 0);
    end
    d_rd = fifo_rd_cs;
    if (fifo_rd_cs) begin
      rd_n++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (m_valid) begin
      v_n++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (m_ready) got.push_back(m_data);
    end
    @(posedge clk);
    #1;
    if (d_rd && fifo_q.size() != 0)
      fifo_data_out = fifo_q.pop_front();
    fifo_empty = fifo_q.size() == 0;
    if (!rst) begin
      skid_m.delete();
      inf_m = 0; st_m = 0; cnt_m = 0;
      model_ok = 1;
    end else begin
      if (e_pop) begin
        void'(skid_m.pop_front());
        cnt_m++;
      end
      if (inf_m) skid_m.push_back(inf_w);
      if (enable)                 st_m = 1;
      else if (st_m == 1)         st_m = 2;
      else if (st_m == 2 && !inf_m) st_m = 0;
      inf_m = e_rd;
      inf_w = hd;
    end
    cyc++;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    steps(2);
    rst = 1'b1;
    clr_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data_out = '0;
    clr_stats();

    // 1: reset holds off reads with data waiting
    put(8'h11); put(8'h22); put(8'h33);
    enable = 1'b1;
    do_reset();
    chk("rst_rd_cs", fifo_rd_cs, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_count", pop_count, 0);
    chk("rst_idle", idle, 1);
    chk("rst_data", m_data, 0);
    m_ready = 1'b1;
    steps(10);
    chk("s1_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("s1_w0", got[0], 8'h11);
      chk("s1_w1", got[1], 8'h22);
      chk("s1_w2", got[2], 8'h33);
    end

    // 2: streaming at full rate
    do_reset();
    for (int i = 0; i < 8; i++) put(8'(i));
    steps(14);
    chk("s2_rd_n", rd_n, 8);
    chk("s2_rd_span", last_rd - first_rd, 7);
    chk("s2_v_n", v_n, 8);
    chk("s2_v_lat", first_v - first_rd, 2);
    chk("s2_v_span", last_v - first_v, 7);
    chk("s2_count", pop_count, 8);
    chk("s2_n", got.size(), 8);
    for (int i = 0; i < got.size(); i++)
      chk("s2_word", got[i], i);

    // 3: backpressure limits reads to skid depth
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(8'(8'h40 + i));
    steps(8);
    chk("s3_rd_n", rd_n, 2);
    chk("s3_valid", m_valid, 1);
    chk("s3_hold", m_data, 8'h40);
    m_ready = 1'b1;
    steps(10);
    chk("s3_n", got.size(), 4);
    for (int i = 0; i < got.size(); i++)
      chk("s3_word", got[i], 8'h40 + i);
    chk("s3_count", pop_count, 4);

    // 4: single word, empty boundary
    do_reset();
    put(8'hA5);
    steps(8);
    chk("s4_rd_n", rd_n, 1);
    chk("s4_n", got.size(), 1);
    if (got.size() == 1) chk("s4_word", got[0], 8'hA5);

    // 5: stop one cycle after a read
    do_reset();
    for (int i = 0; i < 6; i++) put(8'(8'h50 + i));
    for (int i = 0; i < 10 && rd_n == 0; i++) step();
    enable = 1'b0;
    steps(8);
    chk("s5_rd_n", rd_n, 1);
    chk("s5_n", got.size(), 1);
    chk("s5_idle", idle, 1);
    enable = 1'b1;
    steps(12);
    chk("s5_total", got.size(), 6);
    for (int i = 0; i < got.size(); i++)
      chk("s5_word", got[i], 8'h50 + i);

    // 6: counter wrap at 4 bits
    do_reset();
    for (int i = 0; i < 17; i++) put(8'(8'h80 + i));
    steps(26);
    chk("s6_n", got.size(), 17);
    chk("s6_count", pop_count, 1);

    // random traffic, then drain and score order
    do_reset();
    wr_log.delete();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9) < 4 && fifo_q.size() < 16) begin
        logic [DW-1:0] w;
        w = 8'($urandom);
        put(w);
        wr_log.push_back(w);
      end
      enable  = $urandom_range(7) != 0;
      m_ready = $urandom_range(2) != 0;
      step();
    end
    enable = 1'b1; m_ready = 1'b1;
    steps(40);
    chk("rnd_n", got.size(), wr_log.size());
    for (int i = 0; i < got.size() && i < wr_log.size(); i++)
      chk("rnd_word", got[i], wr_log[i]);
    chk("rnd_count", pop_count, wr_log.size() % 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
